// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The FSM encoding is fixed so that state values stay stable across builds
// and can be matched against in waveforms.
package serial_adder_pkg;

  // Operation phases: wait for operands, add one bit per clock, present result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Majority of three inputs, i.e. the carry-out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// Single-bit full adder used by the serial adder datapath.
// Purely combinational; the top level instances exactly one of these and
// recirculates its carry through a flop.
module serial_adder_full_add_cell
  import serial_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of one bit position.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = maj3(a_i, b_i, ci_i);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: (a + b + cin) computed LSB-first, one bit per clock,
// through a single full-adder cell and a carry flop.
//
// Operands arrive on an in_valid/in_ready handshake and are copied into shift
// registers, so the producer may change a/b/cin right after the accept. The
// result is presented on an out_valid/out_ready handshake and held on
// sum/cout (and ovf) until the next result is complete.
//
// Optional build macro:
//   SERIAL_ADDER_OVF_EN - adds the ovf output carrying two's-complement
//                         overflow of the addition, registered with cout.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must be able to index bit WIDTH-1; sized to WIDTH+1 so WIDTH=1 still
  // yields a legal one-bit counter.
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;

  // Result registers: separate from the working shift register so the visible
  // outputs only change when a full result is ready.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_s;
  logic             bit_co;
  logic [WIDTH-1:0] bit_s_msb;

  serial_adder_full_add_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (c_q),
    .s_o  (bit_s),
    .co_o (bit_co)
  );

  // Place the current sum bit at the MSB so it can be OR-ed into a right shift;
  // avoids a zero-width slice when WIDTH is 1.
  always_comb begin
    bit_s_msb            = '0;
    bit_s_msb[WIDTH-1]   = bit_s;
  end

  // Next-state logic for the FSM and the serial datapath.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        c_d      = bit_co;
        sum_sh_d = (sum_sh_q >> 1) | bit_s_msb;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Last bit: publish the completed word together with its carry-out.
          sum_d   = sum_sh_d;
          cout_d  = bit_co;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on this final cycle.
          ovf_d   = c_q ^ bit_co;
`endif
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decoded directly from the state; DONE never re-accepts.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

  // State, datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Overflow flag register, updated and held alongside cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for directed vectors
// and a 4-bit instance swept over every (a, b, cin) with random backpressure.
// Each instance is shadowed by a transaction-level model (arithmetic result
// plus elapsed-cycle timing) that a negedge compare process checks every cycle.
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       iv4, ir4, ov4, or4, cin4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (ov8),
    .out_ready (or8),
    .sum       (sum8),
    .cout      (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  serial_adder #(.WIDTH(W4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (sum4),
    .cout      (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Transaction model, 8-bit: result = a+b+cin, valid WIDTH edges after accept.
  bit       m8_busy;
  int       m8_age;
  logic [8:0] m8_res, m8_last;
  logic     m8_ovf, m8_last_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_busy     <= 1'b0;
      m8_age      <= 0;
      m8_last     <= '0;
      m8_last_ovf <= 1'b0;
    end else if (!m8_busy) begin
      if (iv8) begin
        m8_busy <= 1'b1;
        m8_age  <= 0;
        m8_res  <= {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
        m8_ovf  <= (a8[7] == b8[7]) && ((a8 + b8 + {7'd0, cin8}) >> 7 != {7'd0, a8[7]});
      end
    end else if (m8_age >= W8 && or8) begin
      m8_busy <= 1'b0;
    end else begin
      m8_age <= m8_age + 1;
      if (m8_age + 1 == W8) begin
        m8_last     <= m8_res;
        m8_last_ovf <= m8_ovf;
      end
    end
  end

  // Transaction model, 4-bit.
  bit       m4_busy;
  int       m4_age;
  logic [4:0] m4_res, m4_last;
  logic     m4_ovf, m4_last_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_busy     <= 1'b0;
      m4_age      <= 0;
      m4_last     <= '0;
      m4_last_ovf <= 1'b0;
    end else if (!m4_busy) begin
      if (iv4) begin
        m4_busy <= 1'b1;
        m4_age  <= 0;
        m4_res  <= {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
        m4_ovf  <= (a4[3] == b4[3]) && ((a4 + b4 + {3'd0, cin4}) >> 3 != {3'd0, a4[3]});
      end
    end else if (m4_age >= W4 && or4) begin
      m4_busy <= 1'b0;
    end else begin
      m4_age <= m4_age + 1;
      if (m4_age + 1 == W4) begin
        m4_last     <= m4_res;
        m4_last_ovf <= m4_ovf;
      end
    end
  end

  // Every-cycle comparison of both DUTs against their models.
  always @(negedge clk) begin
    chk("in_ready8", {31'd0, ir8}, {31'd0, !m8_busy});
    chk("out_valid8", {31'd0, ov8}, {31'd0, (m8_busy && m8_age >= W8)});
    chk("cout_sum8", {23'd0, cout8, sum8}, {23'd0, m8_last});
    chk("in_ready4", {31'd0, ir4}, {31'd0, !m4_busy});
    chk("out_valid4", {31'd0, ov4}, {31'd0, (m4_busy && m4_age >= W4)});
    chk("cout_sum4", {27'd0, cout4, sum4}, {27'd0, m4_last});
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf8", {31'd0, ovf8}, {31'd0, m8_last_ovf});
    chk("ovf4", {31'd0, ovf4}, {31'd0, m4_last_ovf});
`endif
  end

  // Present operands and wait (bounded) for the accepting edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    iv8  = 1'b1;
    a8   = a;
    b8   = b;
    cin8 = c;
    n = 0;
    while (!ir8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout_fail("accept8");
    @(posedge clk);
    #1;
    iv8  = 1'b0;
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    cin8 = 1'($urandom);
  endtask

  // Wait for out_valid; lat counts edges with the accepting edge as 1.
  task automatic finish8(input bit handshake, output logic [8:0] res, output int lat);
    lat = 1;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) timeout_fail("result8");
    res = {cout8, sum8};
    if (handshake) begin
      @(posedge clk);
      #1;
    end
  endtask

  int   hs4 = 0;
  bit   bp4_on = 1'b0;

  // Count completed 4-bit output handshakes.
  always @(posedge clk) begin
    if (rst_n && ov4 && or4) hs4++;
  end

  // Random backpressure on the 4-bit result port.
  always @(posedge clk) begin
    #1;
    if (bp4_on) or4 = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] res;
    int         lat;
    int         n;

    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8 = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    chk("rst_sum", {24'd0, sum8}, 32'h00);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x0F + 0x01 with latency.
    start8(8'h0F, 8'h01, 1'b0);
    finish8(1'b1, res, lat);
    chk("add_0f_01", {23'd0, res}, 32'h010);
    chk("latency", lat, 32'd9);

    // Carry out, no signed overflow.
    start8(8'hFF, 8'h01, 1'b0);
    finish8(1'b1, res, lat);
    chk("add_ff_01", {23'd0, res}, 32'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_ff_01", {31'd0, ovf8}, 32'd0);
`endif

    // Signed overflow, no carry out.
    start8(8'h7F, 8'h01, 1'b0);
    finish8(1'b1, res, lat);
    chk("add_7f_01", {23'd0, res}, 32'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_7f_01", {31'd0, ovf8}, 32'd1);
`endif

    // Backpressure in DONE with new operands pending.
    or8 = 1'b0;
    start8(8'h3C, 8'h0A, 1'b1);
    finish8(1'b0, res, lat);
    chk("bp_result", {23'd0, res}, 32'h047);
    iv8 = 1'b1; a8 = 8'h90; b8 = 8'h90; cin8 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", {31'd0, ir8}, 32'd0);
      chk("bp_out_valid", {31'd0, ov8}, 32'd1);
      chk("bp_hold", {23'd0, cout8, sum8}, 32'h047);
    end
    or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", {31'd0, ir8}, 32'd1);
    chk("bp_idle_valid", {31'd0, ov8}, 32'd0);
    chk("bp_idle_hold", {23'd0, cout8, sum8}, 32'h047);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    finish8(1'b1, res, lat);
    chk("bp_next", {23'd0, res}, 32'h120);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_90_90", {31'd0, ovf8}, 32'd1);
`endif

    // Reset pulse in the third RUN cycle.
    start8(8'h55, 8'h66, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, ov8}, 32'd0);
    chk("abort_in_ready", {31'd0, ir8}, 32'd1);
    chk("abort_sum", {24'd0, sum8}, 32'h00);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start8(8'h22, 8'h11, 1'b1);
    finish8(1'b1, res, lat);
    chk("after_abort", {23'd0, res}, 32'h034);

    // 4-bit exhaustive sweep with random out_ready.
    bp4_on = 1'b1;
    for (int i = 0; i < 512; i++) begin
      iv4  = 1'b1;
      a4   = 4'(i >> 5);
      b4   = 4'(i >> 1);
      cin4 = 1'(i);
      n = 0;
      while (!ir4 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 200) timeout_fail("accept4");
      @(posedge clk);
      #1;
      iv4 = 1'b0;
    end
    n = 0;
    while (!ir4 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout_fail("drain4");
    bp4_on = 1'b0;
    or4 = 1'b1;
    @(posedge clk);
    #1;
    chk("handshakes4", hs4, 32'd512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
